seg7_pattern_reader: RTL and testbench

// - Reverse direction of the segment-decoder blocks: samples a 7-bit segment bus (a..g) and recovers the hex digit it shows.
// - Filters glitches by requiring the pattern to be held for STABLE_CYCLES cycles.
// - Delivers one digit per stable pattern over a valid/ready handshake.
// - Sits between an external/foreign display bus and game logic that consumes the digit values.

---
 rtl/seg7_pattern_reader_if.sv | 28 ++
 rtl/seg7_pattern_reader.sv | 167 ++++++++++++++++
 tb/tb_seg7_pattern_reader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pattern_reader_if.sv
// Segment-bus input and digit valid/ready output bundle for seg7_pattern_reader.
// master = the reader itself, slave = the side driving segments and consuming digits.
interface seg7_pattern_reader_if;
  logic [6:0] seg_in;
  logic [3:0] dig_out;
  logic       dig_err;
  logic       dig_valid;
  logic       dig_ready;
  logic       overrun;

  modport master (
    input  seg_in,
    input  dig_ready,
    output dig_out,
    output dig_err,
    output dig_valid,
    output overrun
  );

  modport slave (
    output seg_in,
    output dig_ready,
    input  dig_out,
    input  dig_err,
    input  dig_valid,
    input  overrun
  );
endinterface

// File: rtl/seg7_pattern_reader.sv
// Recovers the hex digit shown on a 7-segment bus, glitch-filtered, one item per steady pattern.
// Optional macro SEG7_DEDUP_EN: drop an accepted pattern identical to the last emitted one.
module seg7_pattern_reader #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  seg7_pattern_reader_if.master bus_io
);
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int SYNC_W = SYNC_STAGES * 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_TRACK,
    ST_LOCKED
  } state_e;

  logic [SYNC_W-1:0] sync_q;
  logic [6:0]        seg_s;
  logic [6:0]        seg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  state_e            state_q;
  state_e            state_d;
  logic              same;
  logic              accept;
  logic              emit;
  logic              load;
  logic              dup;
  logic [3:0]        dec_digit;
  logic              dec_err;
  logic              valid_q;
  logic              valid_d;
  logic [3:0]        out_q;
  logic [3:0]        out_d;
  logic              err_q;
  logic              err_d;
  logic              ovr_q;
  logic              ovr_d;

  assign seg_s = sync_q[SYNC_W-1 -: 7];
  assign same  = (seg_s == seg_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_TRACK;
    end else begin
      sync_q  <= {sync_q[SYNC_W-8:0], bus_io.seg_in};
      seg_q   <= seg_s;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Locking after an accept is what makes a long steady pattern produce only one item.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_TRACK: begin
        if (same && (cnt_q == CNT_ACC)) begin
          accept  = 1'b1;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!same) begin
          state_d = ST_TRACK;
        end
      end
      default: state_d = ST_TRACK;
    endcase
  end

  always_comb begin
    dec_err   = 1'b0;
    dec_digit = 4'h0;
    case (seg_s)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

`ifdef SEG7_DEDUP_EN
  // Blank is never loaded here, so a 5,blank,5 sequence still matches the stored 5.
  logic [7:0] last_q;

  assign dup = ({dec_err, seg_s} == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= {dec_err, seg_s};
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign emit  = accept && (seg_s != 7'h00) && !dup;
  assign load  = emit && (!valid_q || bus_io.dig_ready);
  assign ovr_d = emit && !load;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    err_d   = err_q;
    if (valid_q && bus_io.dig_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      out_d   = dec_digit;
      err_d   = dec_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= 4'h0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus_io.dig_valid = valid_q;
  assign bus_io.dig_out   = out_q;
  assign bus_io.dig_err   = err_q;
  assign bus_io.overrun   = ovr_q;
endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Bench for seg7_pattern_reader: directed scenarios plus random segment runs checked
// against a run-length reference model of the filter and a one-entry buffer model.
module tb_seg7_pattern_reader;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int LAT  = SYNC + STAB;
  localparam int HMAX = 32768;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_pattern_reader_if bus ();

  seg7_pattern_reader #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [6:0] hist [HMAX];
  int         runStart [HMAX];
  int         edgeCnt = 0;

  logic       mValid = 1'b0;
  logic [3:0] mOut = 4'h0;
  logic       mErr = 1'b0;
  logic       mOvr = 1'b0;
  logic [7:0] mLast = 8'h00;

  int         hsCount = 0;
  int         ovrCount = 0;
  int         validCount = 0;
  int         firstValid = -1;
  logic [3:0] lastHsOut = 4'h0;
  logic       lastHsErr = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void refDecode(input logic [6:0] code, output logic [3:0] d, output logic e);
    d = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == code) begin
        d = 4'(i);
        e = 1'b0;
      end
    end
  endfunction

  // A run of identical samples is accepted once, when it has lasted STAB+1 samples,
  // and the result appears SYNC edges after that sample was taken.
  task automatic modelEdge(input logic [6:0] seg, input logic rdy);
    int         e;
    int         idx;
    logic       acc;
    logic [6:0] code;
    logic [3:0] d;
    logic       er;
    logic       oldValid;
    if (edgeCnt >= HMAX) begin
      $display("[TB] FAIL model_history got=%0d expected<%0d", edgeCnt, HMAX);
      $fatal(1, "[TB] history overflow");
    end
    e = edgeCnt;
    edgeCnt++;
    hist[e] = seg;
    runStart[e] = (e > 0 && hist[e-1] == seg) ? runStart[e-1] : e;
    acc  = 1'b0;
    code = 7'h00;
    d    = 4'h0;
    er   = 1'b0;
    idx  = e - SYNC;
    if (idx >= 0) begin
      if ((idx - runStart[idx]) == STAB && hist[idx] != 7'h00) begin
        acc  = 1'b1;
        code = hist[idx];
      end
    end
    if (acc) begin
      refDecode(code, d, er);
`ifdef SEG7_DEDUP_EN
      if ({er, code} == mLast) acc = 1'b0;
`endif
    end
    oldValid = mValid;
    mOvr = 1'b0;
    if (oldValid && rdy) mValid = 1'b0;
    if (acc) begin
      if (!oldValid || rdy) begin
        mValid = 1'b1;
        mOut   = d;
        mErr   = er;
        mLast  = {er, code};
      end else begin
        mOvr = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("dig_valid", 32'(bus.dig_valid), 32'(mValid));
    checkOutput("overrun", 32'(bus.overrun), 32'(mOvr));
    if (mValid) begin
      checkOutput("dig_out", 32'(bus.dig_out), 32'(mOut));
      checkOutput("dig_err", 32'(bus.dig_err), 32'(mErr));
    end
    if (bus.dig_valid === 1'b1) begin
      validCount++;
      if (firstValid < 0) firstValid = edgeCnt - 1;
    end
    if (bus.overrun === 1'b1) ovrCount++;
  endtask

  // Each cycle starts at a falling edge: drive, note a handshake, take the edge, compare.
  task automatic applyStimulus(input logic [6:0] seg, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      bus.seg_in    = seg;
      bus.dig_ready = rdy;
      if (bus.dig_valid === 1'b1 && rdy) begin
        hsCount++;
        lastHsOut = bus.dig_out;
        lastHsErr = bus.dig_err;
      end
      @(posedge clk);
      modelEdge(seg, rdy);
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(bus.dig_valid), 32'd0);
    checkOutput("rst_out", 32'(bus.dig_out), 32'd0);
    checkOutput("rst_err", 32'(bus.dig_err), 32'd0);
    checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    edgeCnt    = 0;
    mValid     = 1'b0;
    mOut       = 4'h0;
    mErr       = 1'b0;
    mOvr       = 1'b0;
    mLast      = 8'h00;
    firstValid = -1;
    validCount = 0;
  endtask

  initial begin
    int hs0;
    int ov0;
    logic [6:0] code;
    int len;
    bus.seg_in    = 7'h00;
    bus.dig_ready = 1'b0;
    #2;

    // T1: steady 4, latency and single item
    doReset();
    hs0 = hsCount;
    applyStimulus(7'h66, 1'b1, 10);
    checkOutput("t1_items", 32'(hsCount - hs0), 32'd1);
    checkOutput("t1_latency", 32'(firstValid), 32'(LAT));
    checkOutput("t1_valid_cycles", 32'(validCount), 32'd1);
    checkOutput("t1_digit", 32'(lastHsOut), 32'h4);
    checkOutput("t1_err", 32'(lastHsErr), 32'd0);

    // T2: short glitch of 4 before a steady 8
    doReset();
    hs0 = hsCount;
    applyStimulus(7'h66, 1'b1, 2);
    applyStimulus(7'h7F, 1'b1, 12);
    checkOutput("t2_items", 32'(hsCount - hs0), 32'd1);
    checkOutput("t2_digit", 32'(lastHsOut), 32'h8);

    // T3: illegal pattern
    doReset();
    hs0 = hsCount;
    applyStimulus(7'h01, 1'b1, 10);
    checkOutput("t3_items", 32'(hsCount - hs0), 32'd1);
    checkOutput("t3_err", 32'(lastHsErr), 32'd1);
    checkOutput("t3_digit", 32'(lastHsOut), 32'h0);

    // T4: blank never emitted
    doReset();
    applyStimulus(7'h00, 1'b1, 20);
    checkOutput("t4_valid_cycles", 32'(validCount), 32'd0);

    // T5: consumer stalled, second item dropped
    doReset();
    hs0 = hsCount;
    ov0 = ovrCount;
    applyStimulus(7'h06, 1'b0, 8);
    applyStimulus(7'h5B, 1'b0, 10);
    checkOutput("t5_overruns", 32'(ovrCount - ov0), 32'd1);
    checkOutput("t5_held_digit", 32'(bus.dig_out), 32'h1);
    checkOutput("t5_held_valid", 32'(bus.dig_valid), 32'd1);
    applyStimulus(7'h5B, 1'b1, 5);
    checkOutput("t5_items", 32'(hsCount - hs0), 32'd1);
    checkOutput("t5_item_digit", 32'(lastHsOut), 32'h1);
    checkOutput("t5_drained", 32'(bus.dig_valid), 32'd0);

    // T5b: accept coincides with handshake
    doReset();
    ov0 = ovrCount;
    applyStimulus(7'h06, 1'b0, 8);
    applyStimulus(7'h5B, 1'b0, 6);
    applyStimulus(7'h5B, 1'b1, 1);
    applyStimulus(7'h5B, 1'b0, 3);
    checkOutput("t5b_overruns", 32'(ovrCount - ov0), 32'd0);
    checkOutput("t5b_hs_digit", 32'(lastHsOut), 32'h1);
    checkOutput("t5b_reload_valid", 32'(bus.dig_valid), 32'd1);
    checkOutput("t5b_reload_digit", 32'(bus.dig_out), 32'h2);

    // T6: 5, blank, 5
    doReset();
    hs0 = hsCount;
    applyStimulus(7'h6D, 1'b1, 8);
    applyStimulus(7'h00, 1'b1, 8);
    applyStimulus(7'h6D, 1'b1, 8);
    applyStimulus(7'h00, 1'b1, 2);
`ifdef SEG7_DEDUP_EN
    checkOutput("t6_items", 32'(hsCount - hs0), 32'd1);
`else
    checkOutput("t6_items", 32'(hsCount - hs0), 32'd2);
`endif

    // T6b: reset while an item is pending and another is counting
    doReset();
    applyStimulus(7'h06, 1'b0, 8);
    applyStimulus(7'h4F, 1'b0, 3);
    doReset();
    applyStimulus(7'h4F, 1'b0, 10);
    checkOutput("t6b_latency", 32'(firstValid), 32'(LAT));
    checkOutput("t6b_digit", 32'(bus.dig_out), 32'h3);

    // Random runs of legal, blank and arbitrary codes with a random consumer
    doReset();
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        6:       code = 7'h00;
        7, 8, 9: code = 7'($urandom);
        default: code = glyph[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        applyStimulus(code, logic'($urandom_range(0, 9) < 6), 1);
      end
      if ($urandom_range(0, 59) == 0) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
